pipe_adder_n: RTL and testbench

PIPE_ADDER_N -- requirements
Module: pipe_adder_n

---
 rtl/pipe_adder_pkg.sv | 21 ++
 rtl/pipe_adder_n_if.sv | 33 +++
 rtl/pipe_adder_n_adder_chunk.sv | 43 ++++
 rtl/pipe_adder_n.sv | 122 ++++++++++++
 tb/tb_pipe_adder_n.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the pipelined adder.
// Holds default parameters, the chunk-width derivation and a parameter
// legality check used at elaboration time by pipe_adder_n.
package pipe_adder_pkg;

   localparam int unsigned DEF_WIDTH  = 16;
   localparam int unsigned DEF_STAGES = 4;

   // Bits handled by each pipeline stage.
   function automatic int unsigned chunk_width(input int unsigned width,
                                               input int unsigned stages);
      return (stages == 0) ? width : width / stages;
   endfunction

   // WIDTH must split evenly into at least one stage.
   function automatic bit params_ok(input int unsigned width,
                                    input int unsigned stages);
      return (stages >= 1) && (width >= 1) && ((width % stages) == 0);
   endfunction

endpackage

// File: rtl/pipe_adder_n_if.sv
// Valid/ready bus of the pipelined adder.
// Upstream side : in_valid, in_ready, a, b, cin, sub
// Downstream side: out_valid, out_ready, sum, co, ovf
// master = traffic source/sink (bench or neighbours), slave = the adder.
interface pipe_adder_n_if
   import pipe_adder_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             co;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, co, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, co, ovf
   );

endinterface

// File: rtl/pipe_adder_n_adder_chunk.sv
// Combinational ripple-carry building blocks.
// fulladder_1 : a, b, cin -> sum, co (one bit)
// adder_chunk : W-bit ripple adder of fulladder_1 cells; a, b, cin -> sum, co
module fulladder_1 (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic co
);

   assign sum = a ^ b ^ cin;
   assign co  = (a & b) | (cin & (a ^ b));

endmodule

module adder_chunk #(
   parameter int unsigned W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         co
);

   logic [W:0] carry;

   assign carry[0] = cin;

   for (genvar i = 0; i < W; i++) begin : g_bit
      fulladder_1 u_fa (
         .a   (a[i]),
         .b   (b[i]),
         .cin (carry[i]),
         .sum (sum[i]),
         .co  (carry[i+1])
      );
   end

   assign co = carry[W];

endmodule

// File: rtl/pipe_adder_n.sv
// Pipelined WIDTH-bit adder/subtractor, one CHUNK-bit slice per stage.
// Ports: clk, rst (sync, active high), bus (pipe_adder_n_if.slave).
// Stage k adds chunk k with the carry registered by stage k-1. Each stage
// keeps one WIDTH-bit word: unconsumed operand-A chunks in the low part and
// finished sum chunks shifted in from the top, so after the last stage the
// word is the aligned sum. Operand B (already inverted for subtract) shifts
// down alongside it. A single enable stalls the whole pipe.
module pipe_adder_n
   import pipe_adder_pkg::*;
#(
   parameter int unsigned WIDTH  = DEF_WIDTH,
   parameter int unsigned STAGES = DEF_STAGES
) (
   input logic           clk,
   input logic           rst,
   pipe_adder_n_if.slave bus
);

   localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);
   localparam int unsigned LAST  = STAGES - 1;

   if (!params_ok(WIDTH, STAGES)) begin : g_param_err
      $error("pipe_adder_n: WIDTH must be a multiple of STAGES, STAGES >= 1");
   end

   // Stage registers
   logic [WIDTH-1:0] d_q    [STAGES];
   logic [WIDTH-1:0] b_q    [STAGES];
   logic             c_q    [STAGES];
   logic             v_q    [STAGES];
   logic             amsb_q [STAGES];
   logic             bmsb_q [STAGES];
   logic             ovf_q;

   // Stage inputs and next-state values
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] d_in    [STAGES];
   logic [WIDTH-1:0] b_in    [STAGES];
   logic             c_in    [STAGES];
   logic             v_in    [STAGES];
   logic             amsb_in [STAGES];
   logic             bmsb_in [STAGES];
   logic [CHUNK-1:0] ch_sum  [STAGES];
   logic             ch_co   [STAGES];
   logic [WIDTH-1:0] d_d     [STAGES];
   logic [WIDTH-1:0] b_d     [STAGES];
   logic             ovf_d;
   logic             en;

   // Whole pipe advances unless a result is waiting on the output.
   assign en = !v_q[LAST] || bus.out_ready;

   // Stage 0 takes the bus (B and carry inverted for subtract); others chain.
   always_comb begin : stage_inputs
      b_eff      = bus.sub ? ~bus.b : bus.b;
      d_in[0]    = bus.a;
      b_in[0]    = b_eff;
      c_in[0]    = bus.cin ^ bus.sub;
      v_in[0]    = bus.in_valid;
      amsb_in[0] = bus.a[WIDTH-1];
      bmsb_in[0] = b_eff[WIDTH-1];
      for (int k = 1; k < int'(STAGES); k++) begin
         d_in[k]    = d_q[k-1];
         b_in[k]    = b_q[k-1];
         c_in[k]    = c_q[k-1];
         v_in[k]    = v_q[k-1];
         amsb_in[k] = amsb_q[k-1];
         bmsb_in[k] = bmsb_q[k-1];
      end
   end

   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      adder_chunk #(.W(CHUNK)) u_chunk (
         .a   (d_in[g][CHUNK-1:0]),
         .b   (b_in[g][CHUNK-1:0]),
         .cin (c_in[g]),
         .sum (ch_sum[g]),
         .co  (ch_co[g])
      );
   end

   // Consume the low chunk, insert the new sum chunk at the top.
   always_comb begin : stage_next
      for (int k = 0; k < int'(STAGES); k++) begin
         d_d[k] = (d_in[k] >> CHUNK) | (WIDTH'(ch_sum[k]) << (WIDTH - CHUNK));
         b_d[k] = b_in[k] >> CHUNK;
      end
      ovf_d = (amsb_in[LAST] == bmsb_in[LAST]) &&
              (d_d[LAST][WIDTH-1] != amsb_in[LAST]);
   end

   always_ff @(posedge clk) begin : stage_regs
      if (rst) begin
         for (int k = 0; k < int'(STAGES); k++) begin
            d_q[k]    <= '0;
            b_q[k]    <= '0;
            c_q[k]    <= 1'b0;
            v_q[k]    <= 1'b0;
            amsb_q[k] <= 1'b0;
            bmsb_q[k] <= 1'b0;
         end
         ovf_q <= 1'b0;
      end else if (en) begin
         for (int k = 0; k < int'(STAGES); k++) begin
            d_q[k]    <= d_d[k];
            b_q[k]    <= b_d[k];
            c_q[k]    <= ch_co[k];
            v_q[k]    <= v_in[k];
            amsb_q[k] <= amsb_in[k];
            bmsb_q[k] <= bmsb_in[k];
         end
         ovf_q <= ovf_d;
      end
   end

   assign bus.in_ready  = en;
   assign bus.out_valid = v_q[LAST];
   assign bus.sum       = d_q[LAST];
   assign bus.co        = c_q[LAST];
   assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_adder_n.sv
// Self-checking bench for pipe_adder_n (WIDTH=16, STAGES=4).
module tb_pipe_adder_n;
   import pipe_adder_pkg::*;

   localparam int unsigned WIDTH  = 16;
   localparam int unsigned STAGES = 4;

   typedef struct packed {
      logic [15:0] sum;
      logic        co;
      logic        ovf;
   } res_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sub;
      logic [15:0] sum;
      logic        co;
      logic        ovf;
   } vec_t;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   pipe_adder_n_if #(.WIDTH(WIDTH)) bus ();

   pipe_adder_n #(.WIDTH(WIDTH), .STAGES(STAGES)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   checks    = 0;
   int   errors    = 0;
   int   stall_cnt = 0;
   res_t exp_q[$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer arithmetic on the operand values.
   function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                  input logic cin, input logic sub);
      res_t r;
      int   sa;
      int   sb;
      int   su;
      int   ss;
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (!sub) begin
         su = int'(a) + int'(b) + int'(cin);
         ss = sa + sb + int'(cin);
         r.co = (su > 65535);
      end else begin
         su = int'(a) - int'(b) - int'(cin);
         ss = sa - sb - int'(cin);
         r.co = (su >= 0);
      end
      r.sum = 16'(su);
      r.ovf = (ss > 32767) || (ss < -32768);
      return r;
   endfunction

   // Called at a negedge with inputs set; scores this cycle, ends at next negedge.
   task automatic step(output bit acc);
      res_t e;
      #1;
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid && !bus.out_ready) begin
         stall_cnt++;
         chk("stall_in_ready", 32'(bus.in_ready), 0);
         if (exp_q.size() != 0) begin
            chk("stall_sum", 32'(bus.sum), 32'(exp_q[0].sum));
            chk("stall_co", 32'(bus.co), 32'(exp_q[0].co));
         end
      end
      if (bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_output", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("out_sum", 32'(bus.sum), 32'(e.sum));
            chk("out_co", 32'(bus.co), 32'(e.co));
            chk("out_ovf", 32'(bus.ovf), 32'(e.ovf));
         end
      end
      if (acc) exp_q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
      @(negedge clk);
   endtask

   // Single isolated transaction: checks latency and result.
   task automatic run_vec(input int idx, input vec_t v);
      int n;
      bus.a         = v.a;
      bus.b         = v.b;
      bus.cin       = v.cin;
      bus.sub       = v.sub;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      chk($sformatf("vec%0d_in_ready", idx), 32'(bus.in_ready), 1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      n = 1;
      while (!bus.out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("vec%0d_latency", idx), 32'(n), 4);
      chk($sformatf("vec%0d_sum", idx), 32'(bus.sum), 32'(v.sum));
      chk($sformatf("vec%0d_co", idx), 32'(bus.co), 32'(v.co));
      chk($sformatf("vec%0d_ovf", idx), 32'(bus.ovf), 32'(v.ovf));
      @(negedge clk);
   endtask

   // mode 0: back-to-back with a 3-cycle output stall; mode 1: random traffic.
   task automatic run_stream(input int n, input int mode, input int budget);
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sub;
      int          sent;
      int          cyc;
      bit          acc;
      sent = 0;
      cyc  = 0;
      a    = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      b    = 16'($urandom);
      cin  = 1'($urandom);
      sub  = 1'($urandom);
      while ((sent < n || exp_q.size() != 0) && cyc < budget) begin
         bus.in_valid  = (sent < n) && ((mode == 0) || ($urandom_range(0, 3) != 0));
         bus.out_ready = (mode == 0) ? !(cyc >= 6 && cyc <= 8)
                                     : ($urandom_range(0, 2) != 0);
         bus.a   = a;
         bus.b   = b;
         bus.cin = cin;
         bus.sub = sub;
         step(acc);
         if (acc) begin
            sent++;
            a   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            b   = ($urandom_range(0, 7) == 0) ? 16'h0001 : 16'($urandom);
            cin = 1'($urandom);
            sub = 1'($urandom);
         end
         cyc++;
      end
      chk("stream_accepted", 32'(sent), 32'(n));
      chk("stream_drained", 32'(exp_q.size()), 0);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t vecs[10];
      bit   acc;
      int   stale;

      vecs[0] = '{16'h0001, 16'h000B, 1'b1, 1'b0, 16'h000D, 1'b0, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[4] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      vecs[6] = '{16'h1234, 16'h1234, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
      vecs[7] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
      vecs[8] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[9] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.cin       = 1'b0;
      bus.sub       = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);

      chk("reset_out_valid", 32'(bus.out_valid), 0);
      chk("reset_sum", 32'(bus.sum), 0);
      chk("reset_co", 32'(bus.co), 0);
      chk("reset_ovf", 32'(bus.ovf), 0);
      chk("reset_in_ready", 32'(bus.in_ready), 1);
      rst = 1'b0;
      @(negedge clk);

      foreach (vecs[i]) run_vec(i, vecs[i]);

      stall_cnt = 0;
      run_stream(8, 0, 100);
      chk("stall_cycles", 32'(stall_cnt), 3);

      run_stream(200, 1, 3000);

      // Three transactions in flight, then reset with a new input offered.
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.a        = 16'($urandom);
         bus.b        = 16'($urandom);
         bus.cin      = 1'b1;
         bus.sub      = 1'b0;
         step(acc);
         chk("preload_accept", 32'(acc), 1);
      end
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      bus.a        = 16'h1111;
      bus.b        = 16'h2222;
      @(negedge clk);
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      exp_q.delete();
      #1;
      chk("rst_mid_out_valid", 32'(bus.out_valid), 0);
      chk("rst_mid_sum", 32'(bus.sum), 0);
      chk("rst_mid_co", 32'(bus.co), 0);
      chk("rst_mid_ovf", 32'(bus.ovf), 0);
      chk("rst_mid_in_ready", 32'(bus.in_ready), 1);
      stale = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.out_valid) stale++;
      end
      chk("no_stale_after_reset", 32'(stale), 0);

      // Pipe still works after the mid-flight reset.
      run_vec(10, vecs[1]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
